// File: rtl/pwm_output_controller_pkg.sv
// Shared PWM widths, constants and the configuration record used for both the live and shadow copies.
package pwm_pkg;

  localparam int PWM_W   = 8;
  localparam int NUM_OUT = 16;
  localparam logic [PWM_W-1:0] DUTY_FULL = 8'hFF;
  localparam logic [PWM_W-1:0] CNT_LAST  = {PWM_W{1'b1}};

  typedef struct packed {
    logic [NUM_OUT-1:0] en_out;
    logic [NUM_OUT-1:0] en_pwm;
    logic [PWM_W-1:0]   duty;
  } pwm_cfg_t;

  // Full-scale duty is special-cased so 0xFF really means 100% high.
  function automatic logic pwm_level(input logic [PWM_W-1:0] cnt,
                                     input logic [PWM_W-1:0] duty);
    return (duty == DUTY_FULL) ? 1'b1 : (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_output_controller_if.sv
// Register-block facing bundle: live configuration in, registered PWM drive and status out.
interface pwm_output_controller_if;
  import pwm_pkg::*;

  logic [7:0]         en_out_uo;
  logic [7:0]         en_out_uio;
  logic [7:0]         en_pwm_uo;
  logic [7:0]         en_pwm_uio;
  logic [PWM_W-1:0]   pwm_duty_cycle;
  logic               cfg_update;
  logic [NUM_OUT-1:0] out;
  logic               period_start;
  logic               cfg_pending;
  logic [PWM_W-1:0]   duty_active;

  modport master (
    output en_out_uo, en_out_uio, en_pwm_uo, en_pwm_uio, pwm_duty_cycle, cfg_update,
    input  out, period_start, cfg_pending, duty_active
  );

  modport slave (
    input  en_out_uo, en_out_uio, en_pwm_uo, en_pwm_uio, pwm_duty_cycle, cfg_update,
    output out, period_start, cfg_pending, duty_active
  );

endinterface

// File: rtl/pwm_output_controller_tick.sv
// Prescaler counting 0..CLK_DIV-1; tick is high on the last count (every cycle when CLK_DIV=1).
module pwm_tick_gen #(
  parameter int CLK_DIV = 13,
  parameter int PRESC_W = 12
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);

  logic [PRESC_W-1:0] presc;

  assign tick = (presc == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_output_controller.sv
// 16-output PWM driver; configuration is shadowed and only swapped in at a PWM period boundary.
module pwm_output_controller
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = 13,
  parameter int PRESC_W = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pwm_output_controller_if.slave bus
);

  logic               tick;
  logic               boundary;
  logic               load;
  logic               pwm_hi;
  logic [PWM_W-1:0]   pwm_cnt;
  logic               pending;
  logic               period_start_q;
  logic [NUM_OUT-1:0] out_q;
  pwm_cfg_t           live;
  pwm_cfg_t           shadow;

  pwm_tick_gen #(
    .CLK_DIV (CLK_DIV),
    .PRESC_W (PRESC_W)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign live.en_out = {bus.en_out_uio, bus.en_out_uo};
  assign live.en_pwm = {bus.en_pwm_uio, bus.en_pwm_uo};
  assign live.duty   = bus.pwm_duty_cycle;

  assign boundary = tick && (pwm_cnt == CNT_LAST);
  // An update landing on the boundary cycle itself is taken immediately.
  assign load     = boundary && (pending || bus.cfg_update);
  assign pwm_hi   = pwm_level(pwm_cnt, shadow.duty);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt        <= '0;
      shadow         <= '0;
      pending        <= 1'b0;
      period_start_q <= 1'b0;
      out_q          <= '0;
    end else begin
      if (tick) begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end
      if (load) begin
        shadow <= live;
      end
      pending        <= load ? 1'b0 : (pending | bus.cfg_update);
      period_start_q <= boundary;
      out_q          <= shadow.en_out & (~shadow.en_pwm | {NUM_OUT{pwm_hi}});
    end
  end

  assign bus.out          = out_q;
  assign bus.period_start = period_start_q;
  assign bus.cfg_pending  = pending;
  assign bus.duty_active  = shadow.duty;

endmodule

// File: tb/tb_pwm_output_controller.sv
// Directed bench for pwm_output_controller at CLK_DIV=2 (512-cycle period); inputs change and outputs are sampled on negedge.
module tb_pwm_output_controller;

  logic clk;
  logic rst_n;
  int   vectors;
  int   errors;

  pwm_output_controller_if bus ();

  pwm_output_controller #(
    .CLK_DIV (2),
    .PRESC_W (12)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pulse_update();
    bus.cfg_update = 1'b1;
    @(negedge clk);
    bus.cfg_update = 1'b0;
  endtask

  task automatic wait_period_start(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.period_start && n < 2000);
    vectors++;
    if (bus.period_start !== 1'b1) begin
      errors++;
      $display("FAIL %s_wait: period_start not seen after %0d cycles, required within 2000", tag, n);
    end
  endtask

  task automatic test_reset();
    int bad_out, first_ps, ps_cnt;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    vectors++; if (bus.out !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h required 0000", bus.out); end
    vectors++; if (bus.cfg_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b required 0", bus.cfg_pending); end
    vectors++; if (bus.duty_active !== 8'h00) begin errors++; $display("FAIL reset_duty: got %h required 00", bus.duty_active); end
    vectors++; if (bus.period_start !== 1'b0) begin errors++; $display("FAIL reset_ps: got %b required 0", bus.period_start); end
    rst_n = 1'b1;
    bad_out = 0; first_ps = -1; ps_cnt = 0;
    for (int n = 1; n <= 1024; n++) begin
      @(negedge clk);
      if (bus.out !== 16'h0000) bad_out++;
      if (bus.period_start === 1'b1) begin
        ps_cnt++;
        if (first_ps < 0) first_ps = n;
      end
    end
    vectors++; if (bad_out != 0) begin errors++; $display("FAIL idle_out: %0d cycles nonzero, required 0", bad_out); end
    vectors++; if (first_ps != 512) begin errors++; $display("FAIL first_boundary: at cycle %0d required 512", first_ps); end
    vectors++; if (ps_cnt != 2) begin errors++; $display("FAIL idle_ps_count: got %0d required 2", ps_cnt); end
  endtask

  task automatic test_static_enable();
    int n, early;
    bus.en_out_uo = 8'hFF;
    pulse_update();
    vectors++; if (bus.cfg_pending !== 1'b1) begin errors++; $display("FAIL static_pending: got %b required 1", bus.cfg_pending); end
    n = 0; early = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.out !== 16'h0000) early++;
    end while (!bus.period_start && n < 2000);
    vectors++; if (bus.period_start !== 1'b1) begin errors++; $display("FAIL static_wait: no period_start in %0d cycles", n); end
    vectors++; if (n != 511) begin errors++; $display("FAIL static_latency: boundary after %0d cycles required 511", n); end
    vectors++; if (early != 0) begin errors++; $display("FAIL static_early: out nonzero on %0d cycles before load, required 0", early); end
    @(negedge clk);
    vectors++; if (bus.out !== 16'h00FF) begin errors++; $display("FAIL static_out: got %h required 00ff", bus.out); end
  endtask

  task automatic test_duty_half();
    int hi, extra, other;
    logic o1, o257, ps512;
    bus.en_out_uo = 8'h01; bus.en_pwm_uo = 8'h01; bus.pwm_duty_cycle = 8'h80;
    pulse_update();
    wait_period_start("half");
    vectors++; if (bus.duty_active !== 8'h80) begin errors++; $display("FAIL half_duty: got %h required 80", bus.duty_active); end
    hi = 0; extra = 0; other = 0; o1 = 1'b0; o257 = 1'b1; ps512 = 1'b0;
    for (int m = 1; m <= 512; m++) begin
      @(negedge clk);
      if (bus.out[0] === 1'b1) hi++;
      if (bus.out[15:1] !== 15'h0) other++;
      if (m == 1) o1 = bus.out[0];
      if (m == 257) o257 = bus.out[0];
      if (m < 512 && bus.period_start === 1'b1) extra++;
      if (m == 512) ps512 = bus.period_start;
    end
    vectors++; if (hi != 256) begin errors++; $display("FAIL half_high: %0d cycles required 256", hi); end
    vectors++; if (o1 !== 1'b1) begin errors++; $display("FAIL half_first: got %b required 1", o1); end
    vectors++; if (o257 !== 1'b0) begin errors++; $display("FAIL half_fall: got %b required 0", o257); end
    vectors++; if (extra != 0) begin errors++; $display("FAIL half_ps_extra: %0d early pulses required 0", extra); end
    vectors++; if (ps512 !== 1'b1) begin errors++; $display("FAIL half_period: ps at 512 got %b required 1", ps512); end
    vectors++; if (other != 0) begin errors++; $display("FAIL half_other_bits: %0d cycles nonzero required 0", other); end
  endtask

  task automatic test_duty_extremes();
    int hi, lo, ps;
    bus.pwm_duty_cycle = 8'h00;
    pulse_update();
    wait_period_start("zero");
    vectors++; if (bus.duty_active !== 8'h00) begin errors++; $display("FAIL zero_duty: got %h required 00", bus.duty_active); end
    hi = 0;
    for (int m = 1; m <= 512; m++) begin
      @(negedge clk);
      if (bus.out[0] !== 1'b0) hi++;
    end
    vectors++; if (hi != 0) begin errors++; $display("FAIL zero_high: %0d cycles high required 0", hi); end
    bus.pwm_duty_cycle = 8'hFF;
    pulse_update();
    wait_period_start("full");
    vectors++; if (bus.duty_active !== 8'hFF) begin errors++; $display("FAIL full_duty: got %h required ff", bus.duty_active); end
    lo = 0; ps = 0;
    for (int m = 1; m <= 1536; m++) begin
      @(negedge clk);
      if (bus.out[0] !== 1'b1) lo++;
      if (bus.period_start === 1'b1) ps++;
    end
    vectors++; if (lo != 0) begin errors++; $display("FAIL full_low: %0d cycles low required 0", lo); end
    vectors++; if (ps != 3) begin errors++; $display("FAIL full_periods: %0d pulses required 3", ps); end
  endtask

  task automatic test_mid_update();
    int hi;
    logic p201, p511, ps512;
    logic [7:0] d512;
    logic pend512;
    bus.pwm_duty_cycle = 8'h40;
    pulse_update();
    wait_period_start("mid");
    hi = 0; p201 = 1'b0; p511 = 1'b0; ps512 = 1'b0; d512 = 8'h00; pend512 = 1'b1;
    for (int m = 1; m <= 512; m++) begin
      @(negedge clk);
      if (bus.out[0] === 1'b1) hi++;
      if (m == 200) begin bus.pwm_duty_cycle = 8'hC0; bus.cfg_update = 1'b1; end
      if (m == 201) begin bus.cfg_update = 1'b0; p201 = bus.cfg_pending; end
      if (m == 511) p511 = bus.cfg_pending;
      if (m == 512) begin ps512 = bus.period_start; d512 = bus.duty_active; pend512 = bus.cfg_pending; end
    end
    vectors++; if (hi != 128) begin errors++; $display("FAIL mid_old_period: %0d high required 128", hi); end
    vectors++; if (p201 !== 1'b1) begin errors++; $display("FAIL mid_pending_set: got %b required 1", p201); end
    vectors++; if (p511 !== 1'b1) begin errors++; $display("FAIL mid_pending_hold: got %b required 1", p511); end
    vectors++; if (ps512 !== 1'b1) begin errors++; $display("FAIL mid_ps: got %b required 1", ps512); end
    vectors++; if (d512 !== 8'hC0) begin errors++; $display("FAIL mid_duty: got %h required c0", d512); end
    vectors++; if (pend512 !== 1'b0) begin errors++; $display("FAIL mid_pending_clr: got %b required 0", pend512); end
    hi = 0;
    for (int m = 1; m <= 512; m++) begin
      @(negedge clk);
      if (bus.out[0] === 1'b1) hi++;
    end
    vectors++; if (hi != 384) begin errors++; $display("FAIL mid_new_period: %0d high required 384", hi); end
  endtask

  task automatic test_collision();
    for (int m = 1; m <= 511; m++) @(negedge clk);
    vectors++; if (bus.cfg_pending !== 1'b0) begin errors++; $display("FAIL coll_pre_pending: got %b required 0", bus.cfg_pending); end
    bus.pwm_duty_cycle = 8'h55;
    bus.cfg_update = 1'b1;
    @(negedge clk);
    bus.cfg_update = 1'b0;
    vectors++; if (bus.period_start !== 1'b1) begin errors++; $display("FAIL coll_ps: got %b required 1", bus.period_start); end
    vectors++; if (bus.duty_active !== 8'h55) begin errors++; $display("FAIL coll_duty: got %h required 55", bus.duty_active); end
    vectors++; if (bus.cfg_pending !== 1'b0) begin errors++; $display("FAIL coll_pending: got %b required 0", bus.cfg_pending); end
  endtask

  task automatic test_burst();
    for (int m = 1; m <= 512; m++) begin
      @(negedge clk);
      if (m == 10) begin bus.pwm_duty_cycle = 8'h10; bus.cfg_update = 1'b1; end
      if (m == 20) begin bus.pwm_duty_cycle = 8'h20; bus.cfg_update = 1'b1; end
      if (m == 30) begin bus.pwm_duty_cycle = 8'h30; bus.cfg_update = 1'b1; end
      if (m == 11 || m == 21 || m == 31) bus.cfg_update = 1'b0;
      if (m == 100) begin
        vectors++; if (bus.cfg_pending !== 1'b1) begin errors++; $display("FAIL burst_pending: got %b required 1", bus.cfg_pending); end
      end
      if (m == 511) begin
        vectors++; if (bus.duty_active !== 8'h55) begin errors++; $display("FAIL burst_hold: got %h required 55", bus.duty_active); end
      end
      if (m == 512) begin
        vectors++; if (bus.period_start !== 1'b1) begin errors++; $display("FAIL burst_ps: got %b required 1", bus.period_start); end
        vectors++; if (bus.duty_active !== 8'h30) begin errors++; $display("FAIL burst_duty: got %h required 30", bus.duty_active); end
        vectors++; if (bus.cfg_pending !== 1'b0) begin errors++; $display("FAIL burst_pending_clr: got %b required 0", bus.cfg_pending); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int bad_out, early_ps;
    for (int m = 1; m <= 100; m++) @(negedge clk);
    bus.pwm_duty_cycle = 8'h99; bus.en_out_uio = 8'hFF;
    pulse_update();
    vectors++; if (bus.cfg_pending !== 1'b1) begin errors++; $display("FAIL rmid_pending: got %b required 1", bus.cfg_pending); end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (bus.out !== 16'h0000) begin errors++; $display("FAIL rmid_out: got %h required 0000", bus.out); end
    vectors++; if (bus.cfg_pending !== 1'b0) begin errors++; $display("FAIL rmid_pending_drop: got %b required 0", bus.cfg_pending); end
    vectors++; if (bus.duty_active !== 8'h00) begin errors++; $display("FAIL rmid_duty: got %h required 00", bus.duty_active); end
    rst_n = 1'b1;
    bad_out = 0; early_ps = 0;
    for (int n = 1; n <= 512; n++) begin
      @(negedge clk);
      if (bus.out !== 16'h0000) bad_out++;
      if (n < 512 && bus.period_start === 1'b1) early_ps++;
      if (n == 1) begin
        vectors++; if (bus.cfg_pending !== 1'b0) begin errors++; $display("FAIL rmid_post_pending: got %b required 0", bus.cfg_pending); end
      end
      if (n == 100) begin bus.pwm_duty_cycle = 8'h77; bus.cfg_update = 1'b1; end
      if (n == 101) bus.cfg_update = 1'b0;
      if (n == 511) begin
        vectors++; if (bus.duty_active !== 8'h00) begin errors++; $display("FAIL rmid_pre_load: got %h required 00", bus.duty_active); end
      end
      if (n == 512) begin
        vectors++; if (bus.period_start !== 1'b1) begin errors++; $display("FAIL rmid_first_ps: got %b required 1", bus.period_start); end
        vectors++; if (bus.duty_active !== 8'h77) begin errors++; $display("FAIL rmid_load: got %h required 77", bus.duty_active); end
        vectors++; if (bus.cfg_pending !== 1'b0) begin errors++; $display("FAIL rmid_load_pending: got %b required 0", bus.cfg_pending); end
      end
    end
    vectors++; if (bad_out != 0) begin errors++; $display("FAIL rmid_idle_out: %0d cycles nonzero required 0", bad_out); end
    vectors++; if (early_ps != 0) begin errors++; $display("FAIL rmid_early_ps: %0d pulses required 0", early_ps); end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst_n   = 1'b0;
    bus.en_out_uo      = 8'h00;
    bus.en_out_uio     = 8'h00;
    bus.en_pwm_uo      = 8'h00;
    bus.en_pwm_uio     = 8'h00;
    bus.pwm_duty_cycle = 8'h00;
    bus.cfg_update     = 1'b0;
    @(negedge clk);
    test_reset();
    test_static_enable();
    test_duty_half();
    test_duty_extremes();
    test_mid_update();
    test_collision();
    test_burst();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
